// File: rtl/mux32_rr_arbiter.sv
// rtl/mux32_rr_arbiter.sv - four-requester round-robin arbiter driving a shared 32-bit path
//
// Ports:
//   CLK    - clock, all state changes on the rising edge
//   RST    - synchronous active-high reset
//   REQ    - per-requester request, held while the path is wanted
//   I0..I3 - requester data, In belongs to REQ[n]
//   Y      - shared path output, I[S] while VALID else zero
//   S      - registered index of the current owner
//   GNT    - registered one-hot grant
//   VALID  - high while a grant is active
//
// BURST_MAX bounds consecutive grant cycles per owner (1..255).

module mux32_rr_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  REQ,
  input  logic [31:0] I0,
  input  logic [31:0] I1,
  input  logic [31:0] I2,
  input  logic [31:0] I3,
  output logic [31:0] Y,
  output logic [1:0]  S,
  output logic [3:0]  GNT,
  output logic        VALID
);

  localparam logic [7:0] C_BURST = 8'(BURST_MAX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [7:0]  r_cnt;
  logic [1:0]  r_s;
  logic [3:0]  r_gnt;
  logic        r_valid;

  logic [1:0]  w_idle_win;
  logic [1:0]  w_rel_ptr;
  logic [1:0]  w_rel_win;
  logic        w_any;
  logic        w_hold;

  // First requesting index at or after base, wrapping mod 4. Scanning the
  // offsets from farthest to nearest lets the nearest one overwrite.
  function automatic logic [1:0] f_pick(input logic [1:0] base, input logic [3:0] req);
    logic [1:0] idx;
    f_pick = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) f_pick = idx;
    end
  endfunction

  assign w_any      = |REQ;
  assign w_idle_win = f_pick(r_ptr, REQ);
  // A release advances the pointer past the owner; re-arbitration in the
  // same edge must already use that advanced value.
  assign w_rel_ptr  = r_s + 2'd1;
  assign w_rel_win  = f_pick(w_rel_ptr, REQ);
  assign w_hold     = REQ[r_s] && (r_cnt < C_BURST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      r_s     <= 2'd0;
      r_gnt   <= 4'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BUSY;
            r_s     <= w_idle_win;
            r_gnt   <= 4'd1 << w_idle_win;
            r_valid <= 1'b1;
            r_cnt   <= 8'd1;
          end else begin
            r_gnt   <= 4'd0;
            r_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (w_hold) begin
            r_cnt <= r_cnt + 8'd1;
          end else begin
            r_ptr <= w_rel_ptr;
            if (w_any) begin
              // Back-to-back handover, possibly to the same requester.
              r_s     <= w_rel_win;
              r_gnt   <= 4'd1 << w_rel_win;
              r_valid <= 1'b1;
              r_cnt   <= 8'd1;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= 4'd0;
              r_valid <= 1'b0;
              r_cnt   <= 8'd0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'd0;
          r_valid <= 1'b0;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    Y = 32'h0;
    if (r_valid) begin
      case (r_s)
        2'd0:    Y = I0;
        2'd1:    Y = I1;
        2'd2:    Y = I2;
        default: Y = I3;
      endcase
    end
  end

  assign S     = r_s;
  assign GNT   = r_gnt;
  assign VALID = r_valid;

endmodule

// File: tb/tb_mux32_rr_arbiter.sv
// tb/tb_mux32_rr_arbiter.sv - self-checking bench for mux32_rr_arbiter

module tb_mux32_rr_arbiter;

  logic        CLK;
  logic        RST;
  logic [3:0]  REQ;
  logic [3:0]  REQ1;
  logic [31:0] I0, I1, I2, I3;
  logic [31:0] Y, Y1;
  logic [1:0]  S, S1;
  logic [3:0]  GNT, GNT1;
  logic        VALID, VALID1;

  int tests  = 0;
  int failed = 0;

  logic [31:0] dat [4];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic       chk_s;
    int         ptr;
    int         cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  mux32_rr_arbiter #(.BURST_MAX(4)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .Y(Y), .S(S), .GNT(GNT), .VALID(VALID)
  );

  mux32_rr_arbiter #(.BURST_MAX(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ1),
    .I0(I0), .I1(I1), .I2(I2), .I3(I3),
    .Y(Y1), .S(S1), .GNT(GNT1), .VALID(VALID1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] gnt,
                     input logic [1:0] s, input logic valid, input logic chk_s,
                     input int ptr, input int cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.gnt = gnt; v.s = s;
    v.valid = valid; v.chk_s = chk_s; v.ptr = ptr; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    logic [3:0] g1 [5];
    logic [1:0] s1 [5];

    I0 = 32'h1111_0000; I1 = 32'h2222_0001; I2 = 32'h3333_0002; I3 = 32'h4444_0003;
    dat[0] = I0; dat[1] = I1; dat[2] = I2; dat[3] = I3;
    RST = 1'b1; REQ = 4'd0; REQ1 = 4'd0;

    // reset, then 0101 held: four cycles each, then back to 0
    add(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) add(0, 4'b0101, 4'b0001, 2'd0, 1, 1, -1, k + 1);
    for (int k = 0; k < 4; k++) add(0, 4'b0101, 4'b0100, 2'd2, 1, 1, -1, k + 1);
    add(0, 4'b0101, 4'b0001, 2'd0, 1, 1, 3, 1);
    // single requester 3 pulsed for two cycles
    add(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 0, 0);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 1, 0, 1);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 1, 0, 2);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, -1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, -1);
    // lone requester 1 past burst expiry: continuous grant, count restarts
    add(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 0, 0);
    for (int k = 0; k < 9; k++) add(0, 4'b0010, 4'b0010, 2'd1, 1, 1, -1, (k % 4) + 1);
    // reset in the middle of a grant to requester 2
    add(1, 4'b0000, 4'b0000, 2'd0, 0, 1, 0, 0);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 1, 0, 1);
    add(0, 4'b0100, 4'b0100, 2'd2, 1, 1, 0, 2);
    add(1, 4'b0100, 4'b0000, 2'd0, 0, 1, 0, 0);
    add(0, 4'b0110, 4'b0010, 2'd1, 1, 1, 0, 1);
    // non-owner changes ignored; owner drops while another rises
    add(0, 4'b0111, 4'b0010, 2'd1, 1, 1, 0, 2);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 1, 2, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, -1);
    // simultaneous requests resolved by pointer order
    add(0, 4'b1110, 4'b0010, 2'd1, 1, 1, 0, 1);
    add(0, 4'b1100, 4'b0100, 2'd2, 1, 1, 2, 1);
    add(0, 4'b1000, 4'b1000, 2'd3, 1, 1, 3, 1);
    add(0, 4'b0001, 4'b0001, 2'd0, 1, 1, 0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, 1, -1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RST = vecs[i].rst;
      REQ = vecs[i].req;
      sb.push_back(vecs[i]);
      @(posedge CLK);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d gnt", i), 32'(GNT), 32'(e.gnt));
      chk($sformatf("v%0d valid", i), 32'(VALID), 32'(e.valid));
      chk($sformatf("v%0d y", i), Y, e.valid ? dat[e.s] : 32'h0);
      if (e.chk_s) chk($sformatf("v%0d s", i), 32'(S), 32'(e.s));
      if (e.ptr >= 0) chk($sformatf("v%0d ptr", i), 32'(dut.r_ptr), 32'(e.ptr));
      if (e.cnt >= 0) chk($sformatf("v%0d cnt", i), 32'(dut.r_cnt), 32'(e.cnt));
    end

    // BURST_MAX=1 instance rotates every cycle with all four requesting
    g1[0] = 4'b0001; g1[1] = 4'b0010; g1[2] = 4'b0100; g1[3] = 4'b1000; g1[4] = 4'b0001;
    s1[0] = 2'd0; s1[1] = 2'd1; s1[2] = 2'd2; s1[3] = 2'd3; s1[4] = 2'd0;
    @(negedge CLK);
    RST = 1'b1; REQ = 4'd0; REQ1 = 4'd0;
    @(posedge CLK);
    #1;
    chk("b1 reset gnt", 32'(GNT1), 32'h0);
    chk("b1 reset y", Y1, 32'h0);
    @(negedge CLK);
    RST = 1'b0; REQ1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("b1 c%0d gnt", k), 32'(GNT1), 32'(g1[k]));
      chk($sformatf("b1 c%0d s", k), 32'(S1), 32'(s1[k]));
      chk($sformatf("b1 c%0d valid", k), 32'(VALID1), 32'h1);
      chk($sformatf("b1 c%0d y", k), Y1, dat[s1[k]]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
